rr_encode_arbiter: RTL

- Round-robin arbiter that shares one 8-to-3 encoded grant path among 8 requesters.
- Holds a grant while the owner keeps requesting, up to a programmable time limit.
- Rotates priority on each release or timeout.
- Drives a registered one-hot grant plus its 3-bit encoded index, for downstream muxes and address selection.

---
 rtl/rr_encode_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rr_encode_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot and encoded grant.
// An owner keeps the grant while requesting, up to MAX_HOLD cycles (0 = no limit).
module rr_encode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD = MAX_HOLD[7:0];

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, idx_n, own, nxt;
    logic [7:0] cnt, cnt_n, grant_n;
    logic       to_n;
    logic [3:0] sel_req, sel_rel, sel_to;

    // {found, index} of the first set bit scanning upward from p, wrapping
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [3:0] r;
        logic [2:0] j;
        r = '0;
        for (int k = 7; k >= 0; k--) begin
            j = p + 3'(k);
            if (v[j]) r = {1'b1, j};
        end
        return r;
    endfunction

    assign own     = grant_idx;
    assign nxt     = own + 3'd1;
    assign sel_req = pick(req, ptr);
    assign sel_rel = pick(req, nxt);
    assign sel_to  = pick(req & ~grant, nxt);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = grant;
        idx_n   = grant_idx;
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && sel_req[3]) begin
                    state_n = GRANT;
                    grant_n = 8'd1 << sel_req[2:0];
                    idx_n   = sel_req[2:0];
                    cnt_n   = 8'd1;
                end
            end
            GRANT: begin
                if (!enable) begin
                    state_n = IDLE;
                    grant_n = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    ptr_n   = nxt;
                end else if (!req[own]) begin
                    ptr_n = nxt;
                    if (sel_rel[3]) begin
                        grant_n = 8'd1 << sel_rel[2:0];
                        idx_n   = sel_rel[2:0];
                        cnt_n   = 8'd1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        idx_n   = '0;
                        cnt_n   = '0;
                    end
                end else if (HOLD != 8'd0 && cnt == HOLD) begin
                    // forced release; the owner is re-granted if nobody else waits
                    to_n  = 1'b1;
                    ptr_n = nxt;
                    cnt_n = 8'd1;
                    if (sel_to[3]) begin
                        grant_n = 8'd1 << sel_to[2:0];
                        idx_n   = sel_to[2:0];
                    end
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            grant     <= grant_n;
            grant_idx <= idx_n;
            timeout   <= to_n;
        end
    end

    assign grant_valid = |grant;

endmodule
